// File: rtl/ring_counter_pkg.sv
// Shared definitions for the ring / Johnson counter: mode encodings and the
// home-state helper used by the counter.
// No ports; imported by ring_state_check and ring_johnson_counter.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Widest counter the home-state helper can describe; callers size-cast the
  // result down to their own width.
  localparam int HOME_W = 64;

  // Ring home is a single bit at init_pos; Johnson home is all zeros.
  function automatic logic [HOME_W-1:0] home_state(input logic mode,
                                                   input int   n,
                                                   input int   init_pos);
    logic [HOME_W-1:0] r;
    r = '0;
    if ((mode == MODE_RING) && (init_pos < n) && (init_pos >= 0)) begin
      r = HOME_W'(1) << init_pos;
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Legality check for a ring (exactly one bit set) or Johnson (thermometer)
// counter state. Purely combinational, zero latency, no flow control.
// Ports: count (N-bit state), mode (ring/Johnson), legal (1 = state is legal).
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] count,
  input  logic         mode,
  output logic         legal
);

  int ones;
  int edges;

  // A thermometer pattern (0..01..1, 1..10..0, all-0, all-1) has at most
  // one boundary between adjacent bits that differ.
  always_comb begin
    ones  = $countones(count);
    edges = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (count[i] != count[i+1]) begin
        edges = edges + 1;
      end
    end
    legal = (mode == MODE_RING) ? (ones == 1) : (edges <= 1);
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// N-bit one-hot ring / Johnson rotating counter with direction, enable,
// parallel load and a registered wrap pulse. count/wrap: one cycle after the
// qualifying edge; illegal: combinational. No backpressure; en gates shifts.
// Ports: clk, rst_n (sync active-low), en, mode, left, load, load_val[N-1:0]
//        in; count[N-1:0], wrap, illegal out.
// Build option: RING_JOHNSON_SELF_CORRECT_EN enables illegal-state detection
// and recovery to home on the next enabled edge.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter int N        = 8,
  parameter int INIT_POS = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic         left,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         wrap,
  output logic         illegal
);

  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] home;
  logic [N-1:0] shifted;
  logic         fb_lsb;   // bit entering at LSB on a left shift
  logic         fb_msb;   // bit entering at MSB on a right shift

  // Home follows the live mode input, so a reset or wrap compare always uses
  // the mode in force at that edge.
  assign home = N'(home_state(mode, N, INIT_POS));

  // Johnson feeds back the complement of the bit falling off the end.
  assign fb_lsb = (mode == MODE_JOHNSON) ? ~count_q[N-1] : count_q[N-1];
  assign fb_msb = (mode == MODE_JOHNSON) ? ~count_q[0]   : count_q[0];

  always_comb begin
    if (left) begin
      shifted = {count_q[N-2:0], fb_lsb};
    end else begin
      shifted = {fb_msb, count_q[N-1:1]};
    end
  end

`ifdef RING_JOHNSON_SELF_CORRECT_EN
  logic legal;

  ring_state_check #(
    .N (N)
  ) u_state_check (
    .count (count_q),
    .mode  (mode),
    .legal (legal)
  );

  assign illegal = ~legal;
`else
  assign illegal = 1'b0;
`endif

  // Load beats enable; reset is handled in the register block.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
`ifdef RING_JOHNSON_SELF_CORRECT_EN
      if (illegal) begin
        // Recovery jump to home counts as a return to home.
        count_d = home;
        wrap_d  = 1'b1;
      end else begin
        count_d = shifted;
        wrap_d  = (shifted == home);
      end
`else
      count_d = shifted;
      wrap_d  = (shifted == home);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= home;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
